// File: rtl/bmc_rail_seq_ctrl.sv
// bmc_rail_seq_ctrl: S5 sequencer for the BMC aux VR chain and BMC SRST#. It powers rails up in order and down in reverse.
// Latency: outputs decode from registered state. In RUN, SRST# follows iDediBusy_n one cycle late.
// Config: define BMC_SEQ_RETRY_EN to retry PWRUP timeouts up to MAX_RETRY times before FAULT.
module bmc_rail_seq_ctrl #(
  parameter int NUM_RAILS     = 3,
  parameter int PG_TIMEOUT_MS = 10,
  parameter int SRST_DLY_MS   = 2,
  parameter int OFF_DLY_MS    = 1
`ifdef BMC_SEQ_RETRY_EN
  ,
  parameter int MAX_RETRY     = 2
`endif
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 i1mSCE,
  input  logic                 iGoOutFltSt,
  input  logic                 iAuxPwrgd,
  input  logic                 iSlpSus_n,
  input  logic                 iCycleReq,
  input  logic [NUM_RAILS-1:0] ivPwrgd,
  input  logic                 iDediBusy_n,
  output logic [NUM_RAILS-1:0] ovRailEn,
  output logic                 oSrst_n,
  output logic                 oBmcPwrgd,
  output logic                 oBmcPwrFlt,
  output logic [NUM_RAILS-1:0] ovFltRail,
  output logic [2:0]           oState
);

  localparam int IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_RAILS - 1);
  localparam logic [NUM_RAILS-1:0] ONE      = NUM_RAILS'(1);
  localparam logic [NUM_RAILS-1:0] ALL_ON   = {NUM_RAILS{1'b1}};

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_SHDN   = 3'd4,
    ST_COOL   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  state_t               r_state, w_next;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [7:0]           r_tmr;
  logic                 r_cyc, w_cyc_nxt;
  logic                 r_srst_n;
  logic [NUM_RAILS-1:0] r_flt_rail, w_flt_val;
  logic                 w_flt_set;
  logic [NUM_RAILS-1:0] w_idx_oh, w_low_mask, w_low_bad, w_all_bad;
  logic                 w_pg_tmo, w_srst_exp, w_off_exp, w_tmr_clr;
`ifdef BMC_SEQ_RETRY_EN
  logic [1:0]           r_retry, w_retry_nxt;
`endif

  // Isolates the lowest set bit, so the lowest failing rail wins.
  function automatic logic [NUM_RAILS-1:0] lowest(input logic [NUM_RAILS-1:0] v);
    return v & (~v + ONE);
  endfunction

  assign w_idx_oh   = ONE << r_idx;
  assign w_low_mask = w_idx_oh - ONE;
  assign w_low_bad  = ~ivPwrgd & w_low_mask;
  assign w_all_bad  = ~ivPwrgd;

  // An N-ms delay expires on the Nth tick after the timer clear.
  assign w_pg_tmo   = i1mSCE && (r_tmr == 8'(PG_TIMEOUT_MS - 1));
  assign w_srst_exp = i1mSCE && (r_tmr == 8'(SRST_DLY_MS - 1));
  assign w_off_exp  = i1mSCE && (r_tmr == 8'(OFF_DLY_MS - 1));
  assign w_tmr_clr  = (w_next != r_state) || (w_idx_nxt != r_idx);

  // Next-state logic. Priority is fault, then SLP_SUS#/cycle request, then normal progress.
  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    w_cyc_nxt = r_cyc;
    w_flt_set = 1'b0;
    w_flt_val = '0;
`ifdef BMC_SEQ_RETRY_EN
    w_retry_nxt = r_retry;
`endif
    case (r_state)
      ST_OFF: begin
        if (iAuxPwrgd && iSlpSus_n) begin
          w_next    = ST_PWRUP;
          w_idx_nxt = '0;
        end
      end
      ST_PWRUP: begin
        if (!iAuxPwrgd) begin
          w_next    = ST_FAULT;
          w_flt_set = 1'b1;
        end else if (|w_low_bad) begin
          w_next    = ST_FAULT;
          w_flt_set = 1'b1;
          w_flt_val = lowest(w_low_bad);
        end else if (w_pg_tmo) begin
`ifdef BMC_SEQ_RETRY_EN
          if (r_retry < 2'(MAX_RETRY)) begin
            w_next      = ST_COOL;
            w_retry_nxt = r_retry + 2'd1;
          end else
`endif
          begin
            w_next    = ST_FAULT;
            w_flt_set = 1'b1;
            w_flt_val = w_idx_oh;
          end
        end else if (ivPwrgd[r_idx]) begin
          if (r_idx == LAST_IDX) w_next = ST_SETTLE;
          else w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      ST_SETTLE, ST_RUN: begin
        if (!iAuxPwrgd) begin
          w_next    = ST_FAULT;
          w_flt_set = 1'b1;
        end else if (|w_all_bad) begin
          w_next    = ST_FAULT;
          w_flt_set = 1'b1;
          w_flt_val = lowest(w_all_bad);
        end else if (!iSlpSus_n || iCycleReq) begin
          // Remember whether this is a power cycle, which must restart after COOL.
          w_next    = ST_SHDN;
          w_idx_nxt = LAST_IDX;
          w_cyc_nxt = iSlpSus_n;
        end else if ((r_state == ST_SETTLE) && w_srst_exp) begin
          w_next = ST_RUN;
        end
      end
      ST_SHDN: begin
        if (w_off_exp) begin
          if (r_idx == '0) w_next = r_cyc ? ST_COOL : ST_OFF;
          else w_idx_nxt = r_idx - IDX_W'(1);
        end
      end
      ST_COOL: begin
        if (w_off_exp) w_next = ST_OFF;
      end
      ST_FAULT: begin
        if (iGoOutFltSt) w_next = ST_OFF;
      end
      default: w_next = ST_OFF;
    endcase
`ifdef BMC_SEQ_RETRY_EN
    if ((w_next == ST_FAULT) || ((w_next == ST_RUN) && (r_state != ST_RUN)) ||
        ((r_state == ST_SHDN) && (w_next == ST_OFF)))
      w_retry_nxt = '0;
`endif
  end

  // State, rail index and shutdown-origin registers.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= ST_OFF;
      r_idx   <= '0;
      r_cyc   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  // ms timer. It clears on any state or rail change and saturates so it never wraps.
  always_ff @(posedge iClk) begin
    if (!iRst_n) r_tmr <= '0;
    else if (w_tmr_clr) r_tmr <= '0;
    else if (i1mSCE && (r_tmr != 8'hFF)) r_tmr <= r_tmr + 8'd1;
  end

  // SRST# is released only in RUN and is held low while Dediprog is active.
  always_ff @(posedge iClk) begin
    if (!iRst_n) r_srst_n <= 1'b0;
    else r_srst_n <= (w_next == ST_RUN) && iDediBusy_n;
  end

  // The failing-rail latch is set on FAULT entry and cleared when leaving FAULT.
  always_ff @(posedge iClk) begin
    if (!iRst_n) r_flt_rail <= '0;
    else if (w_flt_set) r_flt_rail <= w_flt_val;
    else if ((r_state == ST_FAULT) && (w_next == ST_OFF)) r_flt_rail <= '0;
  end

`ifdef BMC_SEQ_RETRY_EN
  // Retry counter for PWRUP timeouts.
  always_ff @(posedge iClk) begin
    if (!iRst_n) r_retry <= '0;
    else r_retry <= w_retry_nxt;
  end
`endif

  // Rail enables: during PWRUP/SHDN, rails 0..idx are on.
  always_comb begin
    ovRailEn = '0;
    case (r_state)
      ST_PWRUP, ST_SHDN:  ovRailEn = w_low_mask | w_idx_oh;
      ST_SETTLE, ST_RUN:  ovRailEn = ALL_ON;
      default:            ovRailEn = '0;
    endcase
  end

  assign oSrst_n    = r_srst_n;
  assign oBmcPwrgd  = (r_state == ST_RUN);
  assign oBmcPwrFlt = (r_state == ST_FAULT);
  assign ovFltRail  = r_flt_rail;
  assign oState     = r_state;

endmodule

// File: tb/tb_bmc_rail_seq_ctrl.sv
// tb_bmc_rail_seq_ctrl: directed bench for bmc_rail_seq_ctrl with a cycle model and literal milestone checks.
// Clock period 10; a 1 ms tick pulses every 10 clocks.
// Inputs change on negedge; outputs are checked on negedge.
module tb_bmc_rail_seq_ctrl;
  localparam int N = 3, PGT = 10, SDLY = 2, ODLY = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i1mSCE;
  logic       go = 1'b0, aux = 1'b0, slp = 1'b0, creq = 1'b0, dedi = 1'b1;
  logic [2:0] pg = 3'b000;
  logic [2:0] ovRailEn, ovFltRail, oState;
  logic       oSrst_n, oBmcPwrgd, oBmcPwrFlt;

  int n_chk = 0, n_err = 0;
  int tcnt = 0;
  int tick_cnt [8];
  int top_cnt = 0;

  // model
  int m_ph = 0, m_on = 0, m_ms = 0;
  logic m_cyc = 1'b0, m_srst = 1'b0;
  logic [2:0] m_flt = 3'b000;
  bit m_valid = 1'b0;

  bmc_rail_seq_ctrl dut (
    .iClk(clk), .iRst_n(rst_n), .i1mSCE(i1mSCE), .iGoOutFltSt(go), .iAuxPwrgd(aux),
    .iSlpSus_n(slp), .iCycleReq(creq), .ivPwrgd(pg), .iDediBusy_n(dedi),
    .ovRailEn(ovRailEn), .oSrst_n(oSrst_n), .oBmcPwrgd(oBmcPwrgd), .oBmcPwrFlt(oBmcPwrFlt),
    .ovFltRail(ovFltRail), .oState(oState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the sequencing rules. It tracks the phase, the count of enabled rails and the ms elapsed.
  task automatic model_step();
    int np, non, low;
    logic [2:0] bad;
    bit tk;
    if (!rst_n) begin
      m_ph = 0; m_on = 0; m_ms = 0; m_cyc = 1'b0; m_flt = 3'b000; m_srst = 1'b0; m_valid = 1'b1;
      return;
    end
    np = m_ph; non = m_on; tk = i1mSCE; bad = ~pg; low = -1;
    for (int i = N - 1; i >= 0; i--) if (bad[i]) low = i;
    case (m_ph)
      0: if (aux && slp) begin np = 1; non = 1; end
      1: begin
        if (!aux) begin np = 6; non = 0; m_flt = 3'b000; end
        else if (low >= 0 && low < m_on - 1) begin np = 6; non = 0; m_flt = 3'(1 << low); end
        else if (tk && m_ms + 1 == PGT) begin np = 6; non = 0; m_flt = 3'(1 << (m_on - 1)); end
        else if (pg[m_on - 1]) begin
          if (m_on == N) np = 2; else non = m_on + 1;
        end
      end
      2, 3: begin
        if (!aux) begin np = 6; non = 0; m_flt = 3'b000; end
        else if (low >= 0) begin np = 6; non = 0; m_flt = 3'(1 << low); end
        else if (!slp || creq) begin np = 4; m_cyc = slp; end
        else if (m_ph == 2 && tk && m_ms + 1 == SDLY) np = 3;
      end
      4: if (tk && m_ms + 1 == ODLY) begin
        non = m_on - 1;
        if (non == 0) np = m_cyc ? 5 : 0;
      end
      5: if (tk && m_ms + 1 == ODLY) np = 0;
      6: if (go) begin np = 0; m_flt = 3'b000; end
      default: np = 0;
    endcase
    if (np != m_ph || non != m_on) m_ms = 0;
    else if (tk) m_ms++;
    m_srst = (np == 3) && dedi;
    m_ph = np; m_on = non;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare the DUT against the model on every cycle.
  initial forever begin
    @(negedge clk);
    if (m_valid)
      chk("model", {oState, ovRailEn, oSrst_n, oBmcPwrgd, oBmcPwrFlt, ovFltRail},
          {3'(m_ph), 3'((1 << m_on) - 1), m_srst, 1'(m_ph == 3), 1'(m_ph == 6), m_flt});
  end

  // Generate the ms tick. Count each tick against the state that will consume it.
  initial begin
    i1mSCE = 1'b0;
    foreach (tick_cnt[i]) tick_cnt[i] = 0;
    forever begin
      @(negedge clk);
      tcnt = (tcnt == 9) ? 0 : tcnt + 1;
      i1mSCE = (tcnt == 9);
      if (i1mSCE) begin
        tick_cnt[oState]++;
        if (oState == 3'd1 && ovRailEn == 3'b111) top_cnt++;
      end
    end
  end

  task automatic clr_cnt();
    #2;
    foreach (tick_cnt[i]) tick_cnt[i] = 0;
    top_cnt = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int b = 0;
    while (oState != s && b < budget) begin @(negedge clk); b++; end
    chk(name, oState, s);
  endtask

  // Rail responder: wait for each enable, check the enable pattern, then assert PG 1 ms later.
  task automatic power_up(input int last);
    logic [2:0] en_tab [3];
    en_tab[0] = 3'b001; en_tab[1] = 3'b011; en_tab[2] = 3'b111;
    for (int i = 0; i <= last; i++) begin
      int b = 0;
      while (!ovRailEn[i] && b < 300) begin @(negedge clk); b++; end
      chk("rail_en_order", ovRailEn, en_tab[i]);
      repeat (10) @(negedge clk);
      pg[i] = 1'b1;
    end
  endtask

  initial begin
    int b;
    repeat (3) @(negedge clk);
    chk("rst_state", oState, 0);
    chk("rst_railen", ovRailEn, 0);
    chk("rst_srst", oSrst_n, 0);
    chk("rst_pwrgd", oBmcPwrgd, 0);
    chk("rst_flt", oBmcPwrFlt, 0);
    chk("rst_fltrail", ovFltRail, 0);
    rst_n = 1'b1;

    // 1: normal power-up
    clr_cnt();
    @(negedge clk);
    aux = 1'b1; slp = 1'b1; dedi = 1'b1;
    power_up(2);
    wait_state(3'd3, 100, "t1_run");
    chk("t1_settle_ms", tick_cnt[2], 2);
    chk("t1_pwrgd", oBmcPwrgd, 1);
    chk("t1_srst", oSrst_n, 1);
    chk("t1_railen", ovRailEn, 3'b111);

    // 6: Dediprog holds SRST#
    @(negedge clk); dedi = 1'b0;
    @(negedge clk);
    chk("t6_srst_low", oSrst_n, 0);
    chk("t6_pwrgd_kept", oBmcPwrgd, 1);
    repeat (3) @(negedge clk);
    dedi = 1'b1;
    @(negedge clk);
    chk("t6_srst_back", oSrst_n, 1);

    // 2: rail 1 glitch in RUN
    @(negedge clk); pg = 3'b101;
    @(negedge clk); pg = 3'b111;
    chk("t2_state", oState, 6);
    chk("t2_railen", ovRailEn, 0);
    chk("t2_srst", oSrst_n, 0);
    chk("t2_flt", oBmcPwrFlt, 1);
    chk("t2_fltrail", ovFltRail, 3'b010);
    repeat (5) @(negedge clk);
    chk("t2_latched", oState, 6);
    pg = 3'b000; go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("t2_off", oState, 0);
    chk("t2_flt_clr", oBmcPwrFlt, 0);
    chk("t2_fltrail_clr", ovFltRail, 0);

    // 3: SLP_SUS# fall in RUN
    power_up(2);
    wait_state(3'd3, 100, "t3_run");
    clr_cnt();
    @(negedge clk); slp = 1'b0;
    @(negedge clk);
    chk("t3_shdn", oState, 4);
    chk("t3_srst", oSrst_n, 0);
    chk("t3_pwrgd", oBmcPwrgd, 0);
    chk("t3_railen", ovRailEn, 3'b111);
    wait_state(3'd0, 100, "t3_off");
    chk("t3_shdn_ms", tick_cnt[4], 3);
    chk("t3_no_cool", tick_cnt[5], 0);
    pg = 3'b000;
    repeat (40) @(negedge clk);
    chk("t3_stay_off", oState, 0);
    chk("t3_off_railen", ovRailEn, 0);

    // 4: power cycle request
    slp = 1'b1;
    power_up(2);
    wait_state(3'd3, 100, "t4_run");
    clr_cnt();
    @(negedge clk); creq = 1'b1;
    @(negedge clk); creq = 1'b0;
    chk("t4_shdn", oState, 4);
    b = 0;
    while (ovRailEn != 3'b011 && b < 100) begin @(negedge clk); b++; end
    chk("t4_mid_shdn", ovRailEn, 3'b011);
    creq = 1'b1;
    @(negedge clk); creq = 1'b0;
    wait_state(3'd5, 100, "t4_cool");
    pg = 3'b000;
    power_up(2);
    wait_state(3'd3, 100, "t4_rerun");
    chk("t4_shdn_ms", tick_cnt[4], 3);
    chk("t4_cool_ms", tick_cnt[5], 1);

    // 5: rail 2 never good
    @(negedge clk); slp = 1'b0;
    wait_state(3'd0, 200, "t5_off");
    pg = 3'b000;
    clr_cnt();
    @(negedge clk); slp = 1'b1;
    power_up(1);
    wait_state(3'd6, 300, "t5_fault");
    chk("t5_timeout_ms", top_cnt, 10);
    chk("t5_fltrail", ovFltRail, 3'b100);
    chk("t5_railen", ovRailEn, 0);
    chk("t5_flt", oBmcPwrFlt, 1);
    chk("t5_pwrgd", oBmcPwrgd, 0);
    pg = 3'b000; aux = 1'b0; go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("t5_off", oState, 0);
    chk("t5_fltrail_clr", ovFltRail, 0);

    // reset in the middle of PWRUP
    aux = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst2_pwrup", oState, 1);
    chk("rst2_railen_pre", ovRailEn, 3'b001);
    rst_n = 1'b0; aux = 1'b0;
    @(negedge clk);
    chk("rst2_state", oState, 0);
    chk("rst2_railen", ovRailEn, 0);
    chk("rst2_srst", oSrst_n, 0);
    chk("rst2_pwrgd", oBmcPwrgd, 0);
    chk("rst2_flt", oBmcPwrFlt, 0);
    chk("rst2_fltrail", ovFltRail, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst2_stay_off", oState, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end
endmodule
